// File: rtl/fu_scheduler.sv
// Per-lane functional-unit occupancy tracker for the issue stage: one countdown
// per lane covers the non-pipelined multiplier; ALU ops never occupy a lane.
module fu_scheduler #(
    parameter int WAYS     = 3,
    parameter int MULT_LAT = 4,
    parameter int CW       = $clog2(MULT_LAT)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_squash,
    input  logic [WAYS-1:0]         i_issue_valid,
    input  logic [WAYS-1:0]         i_issue_is_mult,
    output logic [WAYS-1:0]         o_ALU_occupied,
    output logic [WAYS-1:0]         o_mult_done,
    output logic [$clog2(WAYS):0]   o_num_lanes_free,
    output logic                    o_issue_error
);

    localparam int              NFW  = $clog2(WAYS) + 1;
    localparam logic [CW-1:0]   LOAD = CW'(MULT_LAT - 1);

    logic [CW-1:0]   r_cnt [WAYS];
    logic            r_issue_error;

    logic [WAYS-1:0] w_busy;
    logic [WAYS-1:0] w_last;
    logic [WAYS-1:0] w_accept_mult;
    logic [WAYS-1:0] w_reject;
    logic [NFW-1:0]  w_free;

    // Lane status decode; occupancy depends only on the counters so the RS
    // can use it in the same cycle it issues.
    always_comb begin
        w_busy        = '0;
        w_last        = '0;
        w_accept_mult = '0;
        w_reject      = '0;
        w_free        = '0;
        for (int i = 0; i < WAYS; i++) begin
            w_busy[i]        = (r_cnt[i] != '0);
            w_last[i]        = (r_cnt[i] == CW'(1));
            w_accept_mult[i] = i_issue_valid[i] & i_issue_is_mult[i] & ~w_busy[i];
            w_reject[i]      = i_issue_valid[i] & w_busy[i];
            if (!w_busy[i]) begin
                w_free = w_free + NFW'(1);
            end else begin
                w_free = w_free;
            end
        end
    end

    assign o_ALU_occupied   = w_busy;
    assign o_mult_done      = w_last & {WAYS{~i_squash}};
    assign o_num_lanes_free = w_free;
    assign o_issue_error    = r_issue_error;

    // Counter update with reset > squash > accept > decrement; squash also
    // hides rejects so a flushed issue never flags an error.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < WAYS; i++) begin
                r_cnt[i] <= '0;
            end
            r_issue_error <= 1'b0;
        end else if (i_squash) begin
            for (int i = 0; i < WAYS; i++) begin
                r_cnt[i] <= '0;
            end
            r_issue_error <= r_issue_error;
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                if (w_accept_mult[i]) begin
                    r_cnt[i] <= LOAD;
                end else if (w_busy[i]) begin
                    r_cnt[i] <= r_cnt[i] - CW'(1);
                end else begin
                    r_cnt[i] <= r_cnt[i];
                end
            end
            r_issue_error <= r_issue_error | (|w_reject);
        end
    end

endmodule

// File: tb/tb_fu_scheduler.sv
// Self-checking bench for fu_scheduler (WAYS=3, MULT_LAT=4): expected outputs
// per cycle are queued when stimulus is applied and popped when sampled.
module tb_fu_scheduler;

    logic       clock;
    logic       reset;
    logic       squash;
    logic [2:0] issue_valid;
    logic [2:0] issue_is_mult;
    logic [2:0] alu_occupied;
    logic [2:0] mult_done;
    logic [2:0] num_lanes_free;
    logic       issue_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] occ;
        logic [2:0] done;
        logic [2:0] free;
        logic       err;
        string      tag;
    } exp_t;

    exp_t sb[$];

    fu_scheduler #(.WAYS(3), .MULT_LAT(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .i_squash         (squash),
        .i_issue_valid    (issue_valid),
        .i_issue_is_mult  (issue_is_mult),
        .o_ALU_occupied   (alu_occupied),
        .o_mult_done      (mult_done),
        .o_num_lanes_free (num_lanes_free),
        .o_issue_error    (issue_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // One cycle: drive inputs just after the edge, queue what this cycle's
    // outputs must be, then sample mid-cycle and compare.
    task automatic cyc(input logic [2:0] v, input logic [2:0] m, input logic s,
                       input logic r, input logic [2:0] eocc, input logic [2:0] edone,
                       input logic eerr, input string tag);
        exp_t e;
        exp_t got;
        @(posedge clock);
        #1;
        issue_valid   = v;
        issue_is_mult = m;
        squash        = s;
        reset         = r;
        e.occ  = eocc;
        e.done = edone;
        e.free = 3'(3 - $countones(eocc));
        e.err  = eerr;
        e.tag  = tag;
        sb.push_back(e);
        #3;
        got = sb.pop_front();
        checks++;
        if (alu_occupied !== got.occ) begin
            errors++;
            $display("FAIL %s occupied: got %b expected %b", got.tag, alu_occupied, got.occ);
        end
        checks++;
        if (mult_done !== got.done) begin
            errors++;
            $display("FAIL %s mult_done: got %b expected %b", got.tag, mult_done, got.done);
        end
        checks++;
        if (num_lanes_free !== got.free) begin
            errors++;
            $display("FAIL %s free: got %0d expected %0d", got.tag, num_lanes_free, got.free);
        end
        checks++;
        if (issue_error !== got.err) begin
            errors++;
            $display("FAIL %s issue_error: got %b expected %b", got.tag, issue_error, got.err);
        end
    endtask

    task automatic test_reset();
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, "reset_idle0");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, "reset_idle1");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, "reset_idle2");
    endtask

    task automatic test_back_to_back();
        cyc(3'b010, 3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, "b2b_T");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0, "b2b_T1");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0, "b2b_T2");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 3'b010, 1'b0, "b2b_T3");
        cyc(3'b010, 3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, "b2b_T4");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0, "b2b_T5");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0, "b2b_T6");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 3'b010, 1'b0, "b2b_T7");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, "b2b_T8");
    endtask

    task automatic test_alu_stream();
        for (int k = 0; k < 5; k++) begin
            cyc(3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, "alu_stream");
        end
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, "alu_after");
    endtask

    task automatic test_reject();
        cyc(3'b001, 3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, "rej_T");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0, "rej_T1");
        cyc(3'b001, 3'b000, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0, "rej_T2");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b001, 3'b001, 1'b1, "rej_T3");
        cyc(3'b001, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, "rej_T4");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, "rej_T5");
        cyc(3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 1'b1, "rej_clr");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, "rej_cleared");
    endtask

    task automatic test_squash();
        cyc(3'b101, 3'b101, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, "sq_T");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b101, 3'b000, 1'b0, "sq_T1");
        cyc(3'b010, 3'b010, 1'b1, 1'b0, 3'b101, 3'b000, 1'b0, "sq_T2");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, "sq_T3");
        // Squash on the completion cycle, with a would-be reject on lane 2.
        cyc(3'b100, 3'b100, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, "sq2_T");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b100, 3'b000, 1'b0, "sq2_T1");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b100, 3'b000, 1'b0, "sq2_T2");
        cyc(3'b100, 3'b000, 1'b1, 1'b0, 3'b100, 3'b000, 1'b0, "sq2_T3");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, "sq2_T4");
    endtask

    task automatic test_reset_mid();
        cyc(3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, "rm_T");
        cyc(3'b000, 3'b000, 1'b0, 1'b1, 3'b111, 3'b000, 1'b0, "rm_T1");
        for (int k = 0; k < 4; k++) begin
            cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, "rm_after");
        end
    endtask

    task automatic test_mixed_lanes();
        cyc(3'b001, 3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, "mix_T");
        cyc(3'b011, 3'b010, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0, "mix_T1");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b011, 3'b000, 1'b1, "mix_T2");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b011, 3'b001, 1'b1, "mix_T3");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 3'b010, 1'b1, "mix_T4");
        cyc(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, "mix_T5");
    endtask

    initial begin
        reset         = 1'b1;
        squash        = 1'b0;
        issue_valid   = 3'b000;
        issue_is_mult = 3'b000;
        test_reset();
        test_back_to_back();
        test_alu_stream();
        test_reject();
        test_squash();
        test_reset_mid();
        test_mixed_lanes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
